// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : ID-stage scoreboard for long-latency destination registers
//               (load, mul/div). Stalls issue on RAW/WAW hazards against
//               pending writes and on a full scoreboard. A register is
//               released by its write-back or by a flush of its producer.
//               A register released in a cycle is forwardable that cycle.
//               Optional build macro SCOREBOARD_PERF_EN adds the
//               stall_cycles and full_stalls performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
    parameter int MAX_PEND = 4,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             issue_id,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             rs1_used_id,
    input  logic             rs2_used_id,
    input  logic [4:0]       rd_id,
    input  logic             reg_write_id,
    input  logic             long_lat_id,
    input  logic             wb_valid,
    input  logic [4:0]       rd_wb,
    input  logic             flush_ex,
    output logic             stall_id,
    output logic [31:0]      pending_mask,
    output logic [CNT_W-1:0] pend_cnt
`ifdef SCOREBOARD_PERF_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [15:0]      full_stalls
`endif
);

    // Registered scoreboard state
    logic [31:0]      pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_valid_q, last_valid_d;
    logic [4:0]       last_rd_q, last_rd_d;

    // Per-cycle release / hazard terms
    logic [31:0]      clr_mask;
    logic [31:0]      flush_mask;
    logic [31:0]      eff;
    logic [31:0]      set_mask;
    logic             wb_hit;
    logic             flush_hit;
    logic [CNT_W-1:0] cnt_nofill;
    logic             dep_stall;
    logic             full_stall;
    logic             fire;
    logic             set;

    // Releases this cycle: write-back and flush of the producer now in EX
    always_comb begin
        clr_mask = '0;
        if (wb_valid && (rd_wb != 5'd0)) begin
            clr_mask[rd_wb] = 1'b1;
        end
        flush_mask = '0;
        if (flush_ex && last_valid_q) begin
            flush_mask[last_rd_q] = 1'b1;
        end
        // A write-back release is visible to dependents in the same cycle.
        eff       = pending_q & ~clr_mask;
        // Only bits that are actually pending reduce the count; when both
        // sources name the same bit it is counted once, via the write-back.
        wb_hit    = |(pending_q & clr_mask);
        flush_hit = |(pending_q & flush_mask & ~clr_mask);
        cnt_nofill = cnt_q - CNT_W'(wb_hit) - CNT_W'(flush_hit);
    end

    // Hazard detection and the issue/set decision
    always_comb begin
        dep_stall  = (rs1_used_id  & eff[rs1_id])
                   | (rs2_used_id  & eff[rs2_id])
                   | (reg_write_id & eff[rd_id]);
        full_stall = reg_write_id & long_lat_id & (rd_id != 5'd0)
                   & (cnt_nofill == CNT_W'(MAX_PEND));
        stall_id   = issue_id & (dep_stall | full_stall);
        fire       = issue_id & ~stall_id;
        set        = fire & reg_write_id & long_lat_id & (rd_id != 5'd0);
        set_mask   = '0;
        if (set) begin
            set_mask[rd_id] = 1'b1;
        end
    end

    // Next state: clear by write-back, clear by flush, then set (set wins)
    always_comb begin
        pending_d    = (pending_q & ~clr_mask & ~flush_mask) | set_mask;
        pending_d[0] = 1'b0;
        cnt_d        = cnt_nofill + CNT_W'(set);
        // The redirect that flushes EX also empties ID, so nothing is tracked.
        last_valid_d = set & ~flush_ex;
        last_rd_d    = rd_id;
    end

    // State registers, dropped asynchronously on reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending_q    <= '0;
            cnt_q        <= '0;
            last_valid_q <= 1'b0;
            last_rd_q    <= 5'd0;
        end else begin
            pending_q    <= pending_d;
            cnt_q        <= cnt_d;
            last_valid_q <= last_valid_d;
            last_rd_q    <= last_rd_d;
        end
    end

    assign pending_mask = pending_q;
    assign pend_cnt     = cnt_q;

`ifdef SCOREBOARD_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [15:0] full_stalls_q;

    // Stall-cycle counter (wraps) and capacity-only stall counter (saturates)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cycles_q <= 32'd0;
            full_stalls_q  <= 16'd0;
        end else begin
            if (stall_id) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (stall_id && !dep_stall && (full_stalls_q != 16'hFFFF)) begin
                full_stalls_q <= full_stalls_q + 16'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign full_stalls  = full_stalls_q;
`endif

endmodule
`default_nettype wire
